// File: rtl/doc_store_responder.sv
// Fixed-latency memory-side responder: serves the config word at CONFIG_ADDR and
// document words from a host-preloaded store, one outstanding request at a time.
module doc_store_responder #(
   parameter int unsigned BUS_WIDTH    = 512,
   parameter int unsigned DEPTH_WORDS  = 1024,
   parameter int unsigned READ_LATENCY = 4,
   parameter logic [31:0] CONFIG_ADDR  = 32'h0000_2000,
   parameter logic [31:0] DOC_BASE_RST = 32'h0001_0000
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           mem_rd_en,
   input  logic [31:0]                    mem_rd_addr,
   output logic [BUS_WIDTH-1:0]           mem_rd_data,
   output logic                           mem_rd_valid,
   input  logic                           cfg_wr_en,
   input  logic [1:0]                     cfg_strategy,
   input  logic [31:0]                    cfg_doc_base,
   input  logic                           ld_wr_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] ld_wr_addr,
   input  logic [BUS_WIDTH-1:0]           ld_wr_data,
   output logic                           busy,
   output logic [31:0]                    rd_count,
   output logic [15:0]                    err_count
);

   localparam int unsigned BYTES     = BUS_WIDTH / 8;
   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   localparam int unsigned OFFS      = $clog2(BYTES);
   localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS * BYTES);
   localparam logic [3:0]  LAT_INIT  = 4'(READ_LATENCY - 1);
   localparam logic        ONE_CYCLE = (READ_LATENCY == 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   state_e               state_q, state_d;
   logic [3:0]           lat_q, lat_d;
   logic [BUS_WIDTH-1:0] hold_q, hold_d;
   logic [BUS_WIDTH-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 busy_q, busy_d;
   logic [31:0]          cnt_q, cnt_d;
   logic [15:0]          err_q, err_d;
   logic [1:0]           strat_q;
   logic [31:0]          base_q;

   logic [BUS_WIDTH-1:0] store_q [DEPTH_WORDS];

   logic [31:0]          offset_c;
   logic                 is_cfg_c;
   logic                 in_range_c;
   logic [AW-1:0]        word_idx_c;
   logic [BUS_WIDTH-1:0] decoded_c;

   // Document store; not reset, written by the host in any state.
   always_ff @(posedge clk) begin
      if (ld_wr_en) store_q[ld_wr_addr] <= ld_wr_data;
   end

   // Decode; the bound is compared in 33 bits so base+span cannot wrap.
   always_comb begin
      offset_c   = mem_rd_addr - base_q;
      is_cfg_c   = (mem_rd_addr == CONFIG_ADDR);
      in_range_c = (mem_rd_addr >= base_q) && ({1'b0, offset_c} < SPAN);
      word_idx_c = AW'(offset_c >> OFFS);
      decoded_c  = '0;
      if (is_cfg_c) begin
         decoded_c[1:0]   = strat_q;
         decoded_c[63:32] = base_q;
      end else if (in_range_c) begin
         decoded_c = store_q[word_idx_c];
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      hold_d  = hold_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (mem_rd_en) begin
               hold_d = decoded_c;
               if (!is_cfg_c && !in_range_c && err_q != 16'hFFFF) err_d = err_q + 16'd1;
               if (ONE_CYCLE) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  lat_d   = LAT_INIT;
               end
            end
         end
         WAIT: begin
            lat_d = lat_q - 4'd1;
            if (lat_q == 4'd1) state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      valid_d = (state_d == RESP);
      data_d  = valid_d ? hold_d : data_q;
      busy_d  = (state_d != IDLE);
      cnt_d   = valid_d ? cnt_q + 32'd1 : cnt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         lat_q   <= '0;
         hold_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         err_q   <= '0;
         strat_q <= '0;
         base_q  <= DOC_BASE_RST;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         hold_q  <= hold_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         if (cfg_wr_en) begin
            strat_q <= cfg_strategy;
            base_q  <= cfg_doc_base;
         end
      end
   end

   assign mem_rd_data  = data_q;
   assign mem_rd_valid = valid_q;
   assign busy         = busy_q;
   assign rd_count     = cnt_q;
   assign err_count    = err_q;

endmodule

// File: tb/tb_doc_store_responder.sv
// Directed bench for doc_store_responder: a READ_LATENCY=4 instance and a
// READ_LATENCY=1 instance sharing the config/load ports.
module tb_doc_store_responder;

   localparam int unsigned BW = 512;
   localparam logic [31:0] CFG_A = 32'h0000_2000;
   localparam logic [31:0] BASE  = 32'h0001_0000;

   logic          clk;
   logic          rst;
   logic          mem_rd_en, mem_rd_en1;
   logic [31:0]   mem_rd_addr;
   logic [BW-1:0] mem_rd_data, mem_rd_data1;
   logic          mem_rd_valid, mem_rd_valid1;
   logic          cfg_wr_en;
   logic [1:0]    cfg_strategy;
   logic [31:0]   cfg_doc_base;
   logic          ld_wr_en;
   logic [9:0]    ld_wr_addr;
   logic [BW-1:0] ld_wr_data;
   logic          busy, busy1;
   logic [31:0]   rd_count, rd_count1;
   logic [15:0]   err_count, err_count1;

   int n_pass  = 0;
   int n_total = 0;

   doc_store_responder dut (
      .clk(clk), .rst(rst),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
      .cfg_wr_en(cfg_wr_en), .cfg_strategy(cfg_strategy), .cfg_doc_base(cfg_doc_base),
      .ld_wr_en(ld_wr_en), .ld_wr_addr(ld_wr_addr), .ld_wr_data(ld_wr_data),
      .busy(busy), .rd_count(rd_count), .err_count(err_count)
   );

   doc_store_responder #(.READ_LATENCY(1)) dut1 (
      .clk(clk), .rst(rst),
      .mem_rd_en(mem_rd_en1), .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data1), .mem_rd_valid(mem_rd_valid1),
      .cfg_wr_en(cfg_wr_en), .cfg_strategy(cfg_strategy), .cfg_doc_base(cfg_doc_base),
      .ld_wr_en(ld_wr_en), .ld_wr_addr(ld_wr_addr), .ld_wr_data(ld_wr_data),
      .busy(busy1), .rd_count(rd_count1), .err_count(err_count1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [BW-1:0] cfgw(input logic [1:0] s, input logic [31:0] b);
      logic [BW-1:0] w;
      w        = '0;
      w[1:0]   = s;
      w[63:32] = b;
      return w;
   endfunction

   function automatic logic [BW-1:0] pat(input int i);
      return {16{32'(i)}};
   endfunction

   // Steps until valid (bounded); n = edges taken, counting the first edge as 1.
   task automatic wait_valid(output int n);
      n = 0;
      do begin
         step();
         n = n + 1;
      end while (mem_rd_valid !== 1'b1 && n < 20);
      chk("valid_seen", BW'(mem_rd_valid), BW'(1'b1));
   endtask

   // Single request from IDLE; deasserts rd_en in the response cycle and returns to IDLE.
   task automatic req(input string tag, input logic [31:0] a, input logic [BW-1:0] exp);
      int n;
      mem_rd_addr = a;
      mem_rd_en   = 1'b1;
      wait_valid(n);
      chk({tag, "_lat"}, BW'(n), BW'(4));
      chk({tag, "_data"}, mem_rd_data, exp);
      mem_rd_en = 1'b0;
      step();
   endtask

   task automatic load(input logic [9:0] idx, input logic [BW-1:0] d);
      ld_wr_en   = 1'b1;
      ld_wr_addr = idx;
      ld_wr_data = d;
      step();
      ld_wr_en = 1'b0;
   endtask

   initial begin
      int n;
      logic late;
      logic [BW-1:0] p1023;
      p1023 = {8{64'hDEAD_BEEF_0123_4567}};
      rst = 1'b1; mem_rd_en = 1'b0; mem_rd_en1 = 1'b0; mem_rd_addr = '0;
      cfg_wr_en = 1'b0; cfg_strategy = '0; cfg_doc_base = '0;
      ld_wr_en = 1'b0; ld_wr_addr = '0; ld_wr_data = '0;
      step(); step();
      chk("rst_valid", BW'(mem_rd_valid), '0);
      chk("rst_data", mem_rd_data, '0);
      chk("rst_busy", BW'(busy), '0);
      chk("rst_rdcnt", BW'(rd_count), '0);
      chk("rst_errcnt", BW'(err_count), '0);
      rst = 1'b0;
      step();

      // Config fetch
      cfg_wr_en = 1'b1; cfg_strategy = 2'b01; cfg_doc_base = BASE;
      step();
      cfg_wr_en = 1'b0;
      mem_rd_addr = CFG_A; mem_rd_en = 1'b1;
      step();
      chk("t1_busy", BW'(busy), BW'(1'b1));
      n = 1;
      while (mem_rd_valid !== 1'b1 && n < 20) begin step(); n = n + 1; end
      chk("t1_lat", BW'(n), BW'(4));
      chk("t1_data", mem_rd_data, cfgw(2'b01, BASE));
      chk("t1_rdcnt", BW'(rd_count), BW'(1));
      mem_rd_en = 1'b0;
      step();

      // Preload and streaming reads with rd_en held
      for (int i = 0; i < 8; i++) load(10'(i), pat(i));
      load(10'd1023, p1023);
      mem_rd_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         mem_rd_addr = BASE + 32'(64 * i);
         wait_valid(n);
         chk($sformatf("t2_gap%0d", i), BW'(n), BW'((i == 0) ? 4 : 5));
         chk($sformatf("t2_data%0d", i), mem_rd_data, pat(i));
      end
      mem_rd_en = 1'b0;
      step();
      chk("t2_hold_valid", BW'(mem_rd_valid), '0);
      chk("t2_hold_data", mem_rd_data, pat(7));
      chk("t2_rdcnt", BW'(rd_count), BW'(9));
      chk("t2_errcnt", BW'(err_count), '0);

      // Range boundaries
      req("t3_past_end", BASE + 32'h0001_0000, '0);
      req("t3_zero", 32'h0000_0000, '0);
      req("t3_below", BASE - 32'd1, '0);
      req("t3_last_byte", BASE + 32'h0000_FFFF, p1023);
      chk("t3_errcnt", BW'(err_count), BW'(3));

      // Base near the top of the address space
      cfg_wr_en = 1'b1; cfg_strategy = 2'b10; cfg_doc_base = 32'hFFFF_0000;
      step();
      cfg_wr_en = 1'b0;
      req("t3_top_word", 32'hFFFF_FFC0, p1023);
      req("t3_top_cfg", CFG_A, cfgw(2'b10, 32'hFFFF_0000));

      // Config write in the capture cycle returns the old config
      mem_rd_addr = CFG_A; mem_rd_en = 1'b1;
      cfg_wr_en = 1'b1; cfg_strategy = 2'b01; cfg_doc_base = BASE;
      step();
      cfg_wr_en = 1'b0;
      wait_valid(n);
      chk("cfgcol_old", mem_rd_data, cfgw(2'b10, 32'hFFFF_0000));
      mem_rd_en = 1'b0;
      step();
      req("cfgcol_new", CFG_A, cfgw(2'b01, BASE));
      chk("cfg_errcnt", BW'(err_count), BW'(3));

      // Store write in the capture cycle returns the old word
      mem_rd_addr = BASE + 32'd192; mem_rd_en = 1'b1;
      ld_wr_en = 1'b1; ld_wr_addr = 10'd3; ld_wr_data = {64{8'hA5}};
      step();
      ld_wr_en = 1'b0;
      wait_valid(n);
      chk("t4_lat", BW'(n + 1), BW'(4));
      chk("t4_old", mem_rd_data, pat(3));
      wait_valid(n);
      chk("t4_new", mem_rd_data, {64{8'hA5}});
      mem_rd_en = 1'b0;
      step();
      chk("t4_rdcnt", BW'(rd_count), BW'(19));

      // Reset during WAIT drops the request
      mem_rd_addr = BASE + 32'd320; mem_rd_en = 1'b1;
      step(); step();
      rst = 1'b1; mem_rd_en = 1'b0;
      #1;
      chk("t5_valid", BW'(mem_rd_valid), '0);
      chk("t5_busy", BW'(busy), '0);
      chk("t5_rdcnt", BW'(rd_count), '0);
      chk("t5_errcnt", BW'(err_count), '0);
      step();
      rst = 1'b0;
      late = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (mem_rd_valid !== 1'b0) late = 1'b1;
      end
      chk("t5_no_late", BW'(late), '0);
      req("t5_after", BASE + 32'd320, pat(5));
      chk("t5_rdcnt_after", BW'(rd_count), BW'(1));

      // READ_LATENCY=1 instance: response every other cycle
      mem_rd_addr = CFG_A; mem_rd_en1 = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         step();
         chk($sformatf("t6_valid%0d", i), BW'(mem_rd_valid1), BW'(i % 2 == 1));
         if (i % 2 == 1) chk($sformatf("t6_data%0d", i), mem_rd_data1, cfgw(2'b00, BASE));
      end
      mem_rd_en1 = 1'b0;
      chk("t6_rdcnt", BW'(rd_count1), BW'(5));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
